// File: rtl/two_bit_counter.sv
// two_bit_counter
// 2-bit enabled up-counter built as a 4-state binary-encoded FSM.
// The count advances on each rising cp edge while i_x is high and holds while i_x is low.
// o_bit exposes the state register directly.
// o_q is a Mealy carry that is high while the count is 3 and the enable is high.
// o_q can drive the enable of a following counter stage.

module two_bit_counter (
   input  logic       cp,
   input  logic       reset,
   input  logic       i_x,
   output logic       o_q,
   output logic [1:0] o_bit
);

   // The state encoding doubles as the visible count value.
   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t r_state;
   state_t w_nextState;

   // State register: cleared asynchronously while reset is low, otherwise loads the next state.
   always_ff @(posedge cp or negedge reset) begin
      if (!reset) begin
         r_state <= S0;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: hold when disabled, step around the ring S0->S1->S2->S3->S0 when enabled.
   always_comb begin
      w_nextState = r_state;
      if (i_x) begin
         unique case (r_state)
            S0: w_nextState = S1;
            S1: w_nextState = S2;
            S2: w_nextState = S3;
            S3: w_nextState = S0;
         endcase
      end
   end

   // Outputs: the count is the registered state.
   // The carry is gated by reset so that it drops immediately, even before the state register settles.
   always_comb begin
      o_bit = r_state;
      o_q   = 1'b0;
      if (reset && i_x && (r_state == S3)) begin
         o_q = 1'b1;
      end
   end

endmodule

// File: tb/tb_two_bit_counter.sv
// tb_two_bit_counter
// Self-checking bench for two_bit_counter.
// The reference model counts enabled edges since the last reset, so the expected count is that total modulo 4.
// The expected carry is derived from the expected count together with the live enable and reset.
// Directed scenarios pin the expected values with hand-written literals.
// A randomized phase then relies on the per-cycle compare process.

module tb_two_bit_counter;

   logic       cp;
   logic       reset;
   logic       x;
   logic       q;
   logic [1:0] bitOut;

   int checks   = 0;
   int failures = 0;

   // Number of enabled rising edges seen since reset was last low.
   int edgeCount = 0;

   two_bit_counter dut (
      .cp    (cp),
      .reset (reset),
      .i_x   (x),
      .o_q   (q),
      .o_bit (bitOut)
   );

   // Free-running 20 ns clock; rising edges at 10, 30, 50, ...
   initial begin
      cp = 1'b0;
      forever #10 cp = ~cp;
   end

   // Reference model: reset clears the tally, and every enabled rising edge adds one.
   always @(posedge cp or negedge reset) begin
      if (!reset) begin
         edgeCount = 0;
      end else if (x) begin
         edgeCount = edgeCount + 1;
      end
   end

   function automatic logic [1:0] modelBit();
      return 2'(edgeCount % 4);
   endfunction

   function automatic logic modelQ();
      return (reset === 1'b1) && (x === 1'b1) && ((edgeCount % 4) == 3);
   endfunction

   // Compares the DUT outputs against the reference model in the middle of every clock cycle.
   always @(negedge cp) begin
      checks = checks + 1;
      if (bitOut !== modelBit() || q !== modelQ()) begin
         failures = failures + 1;
         $display("[TB] FAIL cycle_compare t=%0t: got bit=%b q=%b, expected bit=%b q=%b",
                  $time, bitOut, q, modelBit(), modelQ());
      end
   end

   // Compares the DUT outputs against hand-computed literal values.
   task automatic checkOutput(input string name, input logic [1:0] expBit, input logic expQ);
      checks = checks + 1;
      if (bitOut !== expBit || q !== expQ) begin
         failures = failures + 1;
         $display("[TB] FAIL %s t=%0t: got bit=%b q=%b, expected bit=%b q=%b",
                  name, $time, bitOut, q, expBit, expQ);
      end
   endtask

   // Drives the enable, then waits the requested number of rising edges.
   // It returns 5 ns after the last edge so that inputs never change on an edge.
   task automatic applyStimulus(input logic newX, input int edges);
      x = newX;
      repeat (edges) @(posedge cp);
      #5;
   endtask

   // Pulses reset low in the middle of a cycle.
   // This leaves the counter at 00 without involving any clock edge.
   task automatic pulseReset();
      #2 reset = 1'b0;
      #2 reset = 1'b1;
   endtask

   initial begin
      logic [1:0] countSeq [5];
      countSeq[0] = 2'b01;
      countSeq[1] = 2'b10;
      countSeq[2] = 2'b11;
      countSeq[3] = 2'b00;
      countSeq[4] = 2'b01;

      reset = 1'b0;
      x     = 1'b0;

      // Reset held low, including across edges and with the enable raised.
      #1 checkOutput("reset_immediate", 2'b00, 1'b0);
      applyStimulus(1'b0, 2);
      checkOutput("reset_across_edges", 2'b00, 1'b0);
      applyStimulus(1'b1, 2);
      checkOutput("reset_ignores_x", 2'b00, 1'b0);

      // Release with the enable low: the counter must hold at zero.
      x = 1'b0;
      reset = 1'b1;
      applyStimulus(1'b0, 3);
      checkOutput("hold_x0", 2'b00, 1'b0);

      // Count through a wrap; the carry is high only while the count is 11.
      x = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1);
         checkOutput($sformatf("count_step%0d", i), countSeq[i], countSeq[i] == 2'b11);
      end

      // Single-cycle enable pulses starting from zero.
      x = 1'b0;
      pulseReset();
      applyStimulus(1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         x = 1'b1;
         #1 checkOutput($sformatf("pulse_carry%0d", i), countSeq[i] - 2'b01, i == 3);
         applyStimulus(1'b1, 1);
         x = 1'b0;
         #1 checkOutput($sformatf("pulse_count%0d", i), countSeq[i], 1'b0);
         applyStimulus(1'b0, 3);
      end

      // The Mealy carry follows the enable between edges while the count sits at 11.
      pulseReset();
      applyStimulus(1'b0, 1);
      applyStimulus(1'b1, 3);
      checkOutput("mealy_q1", 2'b11, 1'b1);
      #2 x = 1'b0;
      #1 checkOutput("mealy_q0", 2'b11, 1'b0);
      #3 x = 1'b1;
      #1 checkOutput("mealy_q1_again", 2'b11, 1'b1);
      applyStimulus(1'b0, 1);
      checkOutput("mealy_after_edge", 2'b11, 1'b0);

      // Asynchronous reset in the middle of counting, then recovery.
      pulseReset();
      applyStimulus(1'b0, 1);
      applyStimulus(1'b1, 2);
      checkOutput("async_pre", 2'b10, 1'b0);
      #2 reset = 1'b0;
      #1 checkOutput("async_immediate", 2'b00, 1'b0);
      applyStimulus(1'b1, 1);
      checkOutput("async_held", 2'b00, 1'b0);
      reset = 1'b1;
      applyStimulus(1'b1, 1);
      checkOutput("async_first_count", 2'b01, 1'b0);

      // Randomized enable with occasional mid-cycle resets; the compare process checks every cycle.
      for (int i = 0; i < 300; i++) begin
         x = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) begin
            pulseReset();
         end
         #1;
         checks = checks + 1;
         if (bitOut !== modelBit() || q !== modelQ()) begin
            failures = failures + 1;
            $display("[TB] FAIL random_mid t=%0t: got bit=%b q=%b, expected bit=%b q=%b",
                     $time, bitOut, q, modelBit(), modelQ());
         end
         @(posedge cp);
         #5;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
